// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C request arbiter slice.
//   ctrl_t           : 8-bit control byte handed from a requester to the master
//   arb_state_e      : arbiter FSM state encoding
//   RST_CODE_DEFAULT : default code driven on reset_register during recovery
//   CTRL_NONE        : control/reset byte meaning "nothing"
//   WDOG_W           : width of the master-done watchdog / recovery counter
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef logic [7:0] ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

    localparam ctrl_t       RST_CODE_DEFAULT = 8'hCC;
    localparam ctrl_t       CTRL_NONE        = 8'h00;
    localparam int unsigned WDOG_W           = 16;

endpackage

// File: rtl/i2c_rr_arb2.sv
// ---------------------------------------------------------------------------
// i2c_rr_arb2
// Two-way round-robin picker with a one-bit priority pointer.
//   clk  : system clock, rising edge
//   rst_ : asynchronous active-low reset (pointer favours req0 afterwards)
//   req  : request vector, bit N = requester N
//   take : the current pick is being consumed this cycle; advance pointer
//   any  : at least one request present
//   pick : index of the winning requester (0 when nothing is requested)
// ---------------------------------------------------------------------------
module i2c_rr_arb2 (
    input  logic       clk,
    input  logic       rst_,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any,
    output logic       pick
);

    // Requester favoured on a tie: the one that was not served last.
    logic prio_q;
    logic prio_d;

    always_comb begin
        any = req[0] | req[1];
        if (req[0] && req[1]) begin
            pick = prio_q;
        end else begin
            pick = req[1];
        end
        prio_d = prio_q;
        if (take && any) begin
            prio_d = ~pick;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
// Arbitrates two transaction requesters onto a single I2C master FSM.
// IDLE -> GRANT (ready pulse, ctrl captured) -> BUSY (master selected)
// -> IDLE with a done pulse. With I2C_ARB_TIMEOUT_EN defined, a watchdog
// in BUSY moves a hung transaction to RECOVER, which drives RST_CODE on
// reset_register for RECOVER_CYCLES cycles and then reports done with error.
// Without I2C_ARB_TIMEOUT_EN, BUSY waits for master_done indefinitely and
// reset_register is tied to 8'h00.
//
// Ports:
//   clk, rst_                : clock, asynchronous active-low reset
//   reqN_valid / reqN_ctrl   : requester N pending flag and control byte
//   reqN_ready               : one-cycle accept pulse (ctrl sampled then)
//   reqN_done, done_err      : one-cycle completion pulse and its error flag
//   master_done, master_err  : completion pulse / error from the I2C master
//   fsm_select_              : active-low select of the master FSM
//   control_reg              : control byte presented to the master
//   reset_register           : reset code to the master, 8'h00 = no reset
// ---------------------------------------------------------------------------
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter ctrl_t       RST_CODE       = RST_CODE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       req0_valid,
    input  logic [7:0] req0_ctrl,
    output logic       req0_ready,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic [7:0] req1_ctrl,
    output logic       req1_ready,
    output logic       req1_done,
    output logic       done_err,
    input  logic       master_done,
    input  logic       master_err,
    output logic       fsm_select_,
    output logic [7:0] control_reg,
    output logic [7:0] reset_register
);

    // Parameter range guards, evaluated at elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("i2c_req_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end
    if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 255) begin : g_bad_recover
        $error("i2c_req_arbiter: RECOVER_CYCLES out of range 1..255");
    end
    // A zero code would be indistinguishable from "no reset".
    if (RST_CODE == CTRL_NONE) begin : g_bad_rst_code
        $error("i2c_req_arbiter: RST_CODE must be non-zero");
    end

    arb_state_e state_q, state_d;
    logic       gnt_idx_q, gnt_idx_d;       // requester owning the current transaction
    ctrl_t      control_reg_q, control_reg_d;
    logic       req0_done_q, req0_done_d;
    logic       req1_done_q, req1_done_d;
    logic       done_err_q, done_err_d;

    logic       arb_any;
    logic       arb_pick;
    logic       arb_take;

    // The pointer only moves when a grant is actually issued from IDLE,
    // so a request held across done competes fairly as a new one.
    assign arb_take = (state_q == ST_IDLE);

    i2c_rr_arb2 u_rr (
        .clk  (clk),
        .rst_ (rst_),
        .req  ({req1_valid, req0_valid}),
        .take (arb_take),
        .any  (arb_any),
        .pick (arb_pick)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    // One counter serves both as BUSY watchdog and RECOVER length counter;
    // it is cleared on entry to each of those states.
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_expired;
    logic              recover_last;

    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign recover_last = (wdog_q == WDOG_W'(RECOVER_CYCLES - 1));
`endif

    always_comb begin
        state_d       = state_q;
        gnt_idx_d     = gnt_idx_q;
        control_reg_d = control_reg_q;
        req0_done_d   = 1'b0;
        req1_done_d   = 1'b0;
        done_err_d    = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        wdog_d        = wdog_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = arb_pick;
                end
            end
            ST_GRANT: begin
                control_reg_d = gnt_idx_q ? req1_ctrl : req0_ctrl;
                state_d       = ST_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                wdog_d        = '0;
`endif
            end
            ST_BUSY: begin
                // master_done takes precedence over an expiring watchdog.
                if (master_done) begin
                    req0_done_d   = ~gnt_idx_q;
                    req1_done_d   = gnt_idx_q;
                    done_err_d    = master_err;
                    control_reg_d = CTRL_NONE;
                    state_d       = ST_IDLE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wdog_expired) begin
                    control_reg_d = CTRL_NONE;
                    wdog_d        = '0;
                    state_d       = ST_RECOVER;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_RECOVER: begin
`ifdef I2C_ARB_TIMEOUT_EN
                if (recover_last) begin
                    req0_done_d = ~gnt_idx_q;
                    req1_done_d = gnt_idx_q;
                    done_err_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`else
                // Unreachable in this build; fall back to IDLE.
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q       <= ST_IDLE;
            gnt_idx_q     <= 1'b0;
            control_reg_q <= CTRL_NONE;
            req0_done_q   <= 1'b0;
            req1_done_q   <= 1'b0;
            done_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_idx_q     <= gnt_idx_d;
            control_reg_q <= control_reg_d;
            req0_done_q   <= req0_done_d;
            req1_done_q   <= req1_done_d;
            done_err_q    <= done_err_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign reset_register = (state_q == ST_RECOVER) ? RST_CODE : CTRL_NONE;
`else
    assign reset_register = CTRL_NONE;
`endif

    assign req0_ready  = (state_q == ST_GRANT) && !gnt_idx_q;
    assign req1_ready  = (state_q == ST_GRANT) &&  gnt_idx_q;
    assign req0_done   = req0_done_q;
    assign req1_done   = req1_done_q;
    assign done_err    = done_err_q;
    assign fsm_select_ = (state_q != ST_BUSY);
    assign control_reg = control_reg_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_req_arbiter
// Directed bench for i2c_req_arbiter: a vector table of transactions plus
// hand-written sequences for reset, idle master_done, mid-BUSY reset and
// watchdog behaviour (build with or without I2C_ARB_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_i2c_req_arbiter;

    localparam int TMO = 64;
    localparam int REC = 16;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int LONG_DLY = 40;
`else
    localparam int LONG_DLY = 100;
`endif

    logic       clk = 1'b0;
    logic       rst_;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_ctrl, req1_ctrl;
    logic       req0_ready, req1_ready;
    logic       req0_done, req1_done, done_err;
    logic       master_done, master_err;
    logic       fsm_select_;
    logic [7:0] control_reg, reset_register;

    int total = 0;
    int passed = 0;

    i2c_req_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .RECOVER_CYCLES (REC),
        .RST_CODE       (8'hCC)
    ) dut (
        .clk            (clk),
        .rst_           (rst_),
        .req0_valid     (req0_valid),
        .req0_ctrl      (req0_ctrl),
        .req0_ready     (req0_ready),
        .req0_done      (req0_done),
        .req1_valid     (req1_valid),
        .req1_ctrl      (req1_ctrl),
        .req1_ready     (req1_ready),
        .req1_done      (req1_done),
        .done_err       (done_err),
        .master_done    (master_done),
        .master_err     (master_err),
        .fsm_select_    (fsm_select_),
        .control_reg    (control_reg),
        .reset_register (reset_register)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       raise0;
        logic       raise1;
        logic [7:0] c0;
        logic [7:0] c1;
        int         dly;
        logic       err;
        logic       exp_idx;
        logic [7:0] exp_ctrl;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(req0_ready || req1_ready) && n < 8) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fsel"},  16'(fsm_select_), 16'h1);
        check({tag, "_creg"},  16'(control_reg), 16'h0);
        check({tag, "_rreg"},  16'(reset_register), 16'h0);
        check({tag, "_ready"}, 16'({req1_ready, req0_ready}), 16'h0);
        check({tag, "_done"},  16'({req1_done, req0_done}), 16'h0);
        check({tag, "_err"},   16'(done_err), 16'h0);
    endtask

    initial begin
        int   n;
        int   m;
        logic seen;
        logic seen_rr;

        vecs[0] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 3,        1'b0, 1'b0, 8'hA1};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 3,        1'b0, 1'b1, 8'hB2};
        vecs[2] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 3,        1'b0, 1'b0, 8'hA1};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 3,        1'b1, 1'b1, 8'hB2};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h3C, 5,        1'b0, 1'b1, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 8'h55, 8'h00, LONG_DLY, 1'b0, 1'b0, 8'h55};
        vecs[6] = '{1'b1, 1'b0, 8'h0F, 8'h00, 1,        1'b0, 1'b0, 8'h0F};

        rst_        = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_ctrl   = 8'h00;
        req1_ctrl   = 8'h00;
        master_done = 1'b0;
        master_err  = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_ = 1'b1;
        tick();

        // master_done while IDLE is ignored
        master_done = 1'b1;
        master_err  = 1'b1;
        tick();
        master_done = 1'b0;
        master_err  = 1'b0;
        check("idle_md_done", 16'({req1_done, req0_done}), 16'h0);
        check("idle_md_fsel", 16'(fsm_select_), 16'h1);
        tick();
        check("idle_md_ready", 16'({req1_ready, req0_ready}), 16'h0);
        check("idle_md_err",   16'(done_err), 16'h0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].raise0) begin
                req0_valid = 1'b1;
                req0_ctrl  = vecs[i].c0;
            end
            if (vecs[i].raise1) begin
                req1_valid = 1'b1;
                req1_ctrl  = vecs[i].c1;
            end
            wait_ready();
            check($sformatf("v%0d_ready0", i), 16'(req0_ready), 16'(!vecs[i].exp_idx));
            check($sformatf("v%0d_ready1", i), 16'(req1_ready), 16'(vecs[i].exp_idx));
            if (vecs[i].exp_idx) req1_valid = 1'b0;
            else                 req0_valid = 1'b0;
            tick();
            check($sformatf("v%0d_busy_fsel", i), 16'(fsm_select_), 16'h0);
            check($sformatf("v%0d_busy_ctrl", i), 16'(control_reg), 16'(vecs[i].exp_ctrl));
            check($sformatf("v%0d_ready_pulse", i), 16'({req1_ready, req0_ready}), 16'h0);
            repeat (vecs[i].dly - 1) tick();
            check($sformatf("v%0d_hold_ctrl", i), 16'(control_reg), 16'(vecs[i].exp_ctrl));
            master_done = 1'b1;
            master_err  = vecs[i].err;
            tick();
            master_done = 1'b0;
            master_err  = 1'b0;
            check($sformatf("v%0d_done0", i), 16'(req0_done), 16'(!vecs[i].exp_idx));
            check($sformatf("v%0d_done1", i), 16'(req1_done), 16'(vecs[i].exp_idx));
            check($sformatf("v%0d_done_err", i), 16'(done_err), 16'(vecs[i].err));
            check($sformatf("v%0d_idle_fsel", i), 16'(fsm_select_), 16'h1);
            check($sformatf("v%0d_idle_ctrl", i), 16'(control_reg), 16'h0);
            check($sformatf("v%0d_idle_rreg", i), 16'(reset_register), 16'h0);
            check($sformatf("v%0d_no_b2b", i), 16'({req1_ready, req0_ready}), 16'h0);
            tick();
            check($sformatf("v%0d_done_clr", i), 16'({req1_done, req0_done}), 16'h0);
        end

        // Reset in the middle of BUSY drops the transaction
        req0_valid = 1'b1;
        req0_ctrl  = 8'h5A;
        wait_ready();
        check("mid_rst_ready", 16'(req0_ready), 16'h1);
        req0_valid = 1'b0;
        tick();
        check("mid_rst_busy_ctrl", 16'(control_reg), 16'h5A);
        repeat (5) tick();
        rst_ = 1'b0;
        #1;
        check_reset_outputs("mid_rst_async");
        tick();
        tick();
        check_reset_outputs("mid_rst_held");
        rst_ = 1'b1;
        seen = 1'b0;
        master_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            master_done = 1'b0;
            seen |= req0_done | req1_done | req0_ready | req1_ready | !fsm_select_;
        end
        check("mid_rst_silent", 16'(seen), 16'h0);

        // Watchdog behaviour
        req0_valid = 1'b1;
        req0_ctrl  = 8'h77;
        wait_ready();
        check("wd_ready", 16'(req0_ready), 16'h1);
        req0_valid = 1'b0;
        tick();
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        while (!fsm_select_ && n < 200) begin
            seen |= req0_done | req1_done;
            n++;
            tick();
        end
        check("wd_busy_cycles", 16'(n), 16'(TMO));
        check("wd_no_early_done", 16'(seen), 16'h0);
        m = 0;
        seen = 1'b0;
        while (reset_register == 8'hCC && m < 100) begin
            seen |= req0_done | req1_done;
            m++;
            tick();
        end
        check("wd_recover_cycles", 16'(m), 16'(REC));
        check("wd_recover_no_done", 16'(seen), 16'h0);
        check("wd_done0", 16'(req0_done), 16'h1);
        check("wd_done_err", 16'(done_err), 16'h1);
        check("wd_after_rreg", 16'(reset_register), 16'h0);
        check("wd_after_fsel", 16'(fsm_select_), 16'h1);
        check("wd_after_ctrl", 16'(control_reg), 16'h0);
        tick();
        check("wd_done_clr", 16'({req1_done, req0_done}), 16'h0);

        // master_done on the final watchdog count wins over the timeout
        req0_valid = 1'b1;
        req0_ctrl  = 8'h66;
        wait_ready();
        check("wd_race_ready", 16'(req0_ready), 16'h1);
        req0_valid = 1'b0;
        tick();
        repeat (TMO - 1) tick();
        check("wd_race_busy", 16'(fsm_select_), 16'h0);
        master_done = 1'b1;
        tick();
        master_done = 1'b0;
        check("wd_race_done0", 16'(req0_done), 16'h1);
        check("wd_race_err", 16'(done_err), 16'h0);
        check("wd_race_rreg", 16'(reset_register), 16'h0);
        tick();
        check("wd_race_no_recover", 16'(reset_register), 16'h0);
        check("wd_race_fsel", 16'(fsm_select_), 16'h1);
`else
        seen = 1'b0;
        seen_rr = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            seen    |= req0_done | req1_done | fsm_select_;
            seen_rr |= (reset_register != 8'h00);
            tick();
        end
        check("nowd_busy_held", 16'(seen), 16'h0);
        check("nowd_rreg_zero", 16'(seen_rr), 16'h0);
        check("nowd_ctrl_held", 16'(control_reg), 16'h77);
        master_done = 1'b1;
        tick();
        master_done = 1'b0;
        check("nowd_done0", 16'(req0_done), 16'h1);
        check("nowd_done_err", 16'(done_err), 16'h0);
        check("nowd_fsel", 16'(fsm_select_), 16'h1);
        n = 0;
        m = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
